reg_bank_wr: RTL and testbench

- 32 x 32-bit MIPS general-purpose register bank, one write port and two read ports.
- Sits downstream of the write-register-address selector: its 5-bit write address comes from the 4:1 address mux (rt / rd / $ra / $sp).
- Its two read ports feed the ALU-operand latches.
- It is the consumer of the selected register index: it decodes that index into one register write per clock, and answers reads by rs/rt index.

---
 rtl/mips_regs_pkg.sv | 41 ++++
 rtl/reg_bank_wr_if.sv | 39 +++
 rtl/reg_rd_port.sv | 29 ++
 rtl/reg_bank_wr.sv | 83 ++++++++
 tb/tb_reg_bank_wr.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mips_regs_pkg.sv
// Shared constants and types for the MIPS general-purpose register file and the
// write-register-address selector that feeds it.
package mips_regs_pkg;

    localparam int unsigned REG_IDX_W      = 5;
    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

    localparam logic [DATA_W_DEFAULT-1:0] SP_RESET_DEFAULT = 32'd227;

    // Source selection used by the upstream write-register-address mux.
    typedef enum logic [1:0] {
        WrSelRt,
        WrSelRd,
        WrSelRa,
        WrSelSp
    } wr_sel_e;

    function automatic reg_idx_t wr_sel_idx(wr_sel_e sel, reg_idx_t rt, reg_idx_t rd);
        reg_idx_t idx;
        unique case (sel)
            WrSelRt: idx = rt;
            WrSelRd: idx = rd;
            WrSelRa: idx = REG_RA;
            WrSelSp: idx = REG_SP;
            default: idx = REG_ZERO;
        endcase
        return idx;
    endfunction

    function automatic logic is_zero_idx(reg_idx_t idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_bank_wr_if.sv
// Write port and two read ports of the register bank, grouped as one bundle.
interface reg_bank_wr_if
    import mips_regs_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);

    logic              wr_en;
    reg_idx_t          wr_addr;
    logic [DATA_W-1:0] wr_data;
    reg_idx_t          rd_addr_a;
    reg_idx_t          rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_ack;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr_a,
        output rd_addr_b,
        input  rd_data_a,
        input  rd_data_b,
        input  wr_ack
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr_a,
        input  rd_addr_b,
        output rd_data_a,
        output rd_data_b,
        output wr_ack
    );

endinterface

// File: rtl/reg_rd_port.sv
// One combinational read port: $zero forcing, then optional same-cycle
// write-data bypass, otherwise the stored register value.
module reg_rd_port
    import mips_regs_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  reg_idx_t          rd_addr_i,
    input  logic              wr_en_i,
    input  reg_idx_t          wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] reg_val_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic bypass_hit;

    always_comb begin
        bypass_hit = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);
        rd_data_o  = reg_val_i;
        if (is_zero_idx(rd_addr_i)) begin
            rd_data_o = '0;
        end else if (bypass_hit) begin
            rd_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/reg_bank_wr.sv
// 32 x DATA_W MIPS register bank: one decoded write per clock, two
// combinational read ports, $zero hardwired and $sp preset on reset.
module reg_bank_wr
    import mips_regs_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEFAULT),
    parameter bit                BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    reg_bank_wr_if.slave  bus
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_dec;
    logic                wr_fire;
    logic                wr_ack_q;
    logic                wr_ack_d;
    logic                rd_wr_en;

    // Writes to $zero are dropped here so neither storage nor wr_ack sees them.
    always_comb begin
        wr_fire = bus.wr_en && !is_zero_idx(bus.wr_addr);
        wr_dec  = '0;
        if (wr_fire) begin
            wr_dec[bus.wr_addr] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = wr_dec[i] ? bus.wr_data : regs_q[i];
        end
        regs_d[REG_ZERO] = '0;
        wr_ack_d         = wr_fire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
            end
            wr_ack_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_ack_q <= wr_ack_d;
        end
    end

    assign bus.wr_ack = wr_ack_q;

    // While reset is held the read ports show reset contents, never bypassed data.
    assign rd_wr_en = bus.wr_en && reset_n;

    reg_rd_port #(
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) u_rd_port_a (
        .rd_addr_i (bus.rd_addr_a),
        .wr_en_i   (rd_wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .reg_val_i (regs_q[bus.rd_addr_a]),
        .rd_data_o (bus.rd_data_a)
    );

    reg_rd_port #(
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) u_rd_port_b (
        .rd_addr_i (bus.rd_addr_b),
        .wr_en_i   (rd_wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .reg_val_i (regs_q[bus.rd_addr_b]),
        .rd_data_o (bus.rd_data_b)
    );

endmodule

// File: tb/tb_reg_bank_wr.sv
// Self-checking bench: a bypassed and a non-bypassed bank driven identically,
// checked every cycle against an array model plus hand-computed literals.
module tb_reg_bank_wr;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    reg_bank_wr_if #(.DATA_W(32)) bus_byp ();
    reg_bank_wr_if #(.DATA_W(32)) bus_nob ();

    reg_bank_wr #(
        .DATA_W   (32),
        .SP_RESET (32'd227),
        .BYPASS   (1'b1)
    ) u_byp (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_byp.slave)
    );

    reg_bank_wr #(
        .DATA_W   (32),
        .SP_RESET (32'd227),
        .BYPASS   (1'b0)
    ) u_nob (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_nob.slave)
    );

    int unsigned nchk = 0;
    int unsigned nerr = 0;

    logic [31:0] model [32];
    logic        exp_ack;
    logic        cur_we;
    logic [4:0]  cur_wa;
    logic [31:0] cur_wd;
    logic [4:0]  cur_ra;
    logic [4:0]  cur_rb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] addr, input logic byp);
        if (addr == 5'd0) return 32'd0;
        if (reset_n && byp && cur_we && cur_wa == addr) return cur_wd;
        return model[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
        exp_ack = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        cur_we = we; cur_wa = wa; cur_wd = wd; cur_ra = ra; cur_rb = rb;
        bus_byp.wr_en = we; bus_byp.wr_addr = wa; bus_byp.wr_data = wd;
        bus_byp.rd_addr_a = ra; bus_byp.rd_addr_b = rb;
        bus_nob.wr_en = we; bus_nob.wr_addr = wa; bus_nob.wr_data = wd;
        bus_nob.rd_addr_a = ra; bus_nob.rd_addr_b = rb;
    endtask

    // One clock edge; the model applies the transaction the way the bank must.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            exp_ack = cur_we && (cur_wa != 5'd0);
            if (exp_ack) model[cur_wa] = cur_wd;
        end
        #1;
    endtask

    always @(negedge clk) begin
        chk("cyc_byp_rd_a", bus_byp.rd_data_a, exp_rd(cur_ra, 1'b1));
        chk("cyc_byp_rd_b", bus_byp.rd_data_b, exp_rd(cur_rb, 1'b1));
        chk("cyc_byp_ack",  {31'd0, bus_byp.wr_ack}, {31'd0, exp_ack});
        chk("cyc_nob_rd_a", bus_nob.rd_data_a, exp_rd(cur_ra, 1'b0));
        chk("cyc_nob_rd_b", bus_nob.rd_data_b, exp_rd(cur_rb, 1'b0));
        chk("cyc_nob_ack",  {31'd0, bus_nob.wr_ack}, {31'd0, exp_ack});
    end

    initial begin
        reset_n = 1'b0;
        model_reset();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        // Fill every register so the reset pulse has something to clear.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'h1000 + 32'(i), 5'(i), 5'(i - 1));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
        #1 chk("fill_29", bus_nob.rd_data_a, 32'h0000101d);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_byp_29", bus_byp.rd_data_a, 32'd227);
        chk("arst_nob_29", bus_nob.rd_data_a, 32'd227);
        chk("arst_nob_5",  bus_nob.rd_data_b, 32'd0);
        chk("arst_ack",    {31'd0, bus_byp.wr_ack}, 32'd0);
        #4 reset_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            #1;
            chk("sweep_a", bus_byp.rd_data_a, (i == 29) ? 32'd227 : 32'd0);
            chk("sweep_b", bus_nob.rd_data_b, (31 - i == 29) ? 32'd227 : 32'd0);
            tick();
        end

        // Basic write, then ack for exactly one cycle.
        drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0);
        tick();
        chk("w8_ack", {31'd0, bus_byp.wr_ack}, 32'd1);
        chk("w8_nob", bus_nob.rd_data_a, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
        tick();
        chk("w8_ack_drop", {31'd0, bus_byp.wr_ack}, 32'd0);
        chk("w8_read_b",   bus_byp.rd_data_b, 32'hDEADBEEF);

        // $zero is hardwired.
        drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        #1 chk("z_byp_pre", bus_byp.rd_data_a, 32'd0);
        tick();
        chk("z_ack", {31'd0, bus_nob.wr_ack}, 32'd0);
        chk("z_rd_b", bus_nob.rd_data_b, 32'd0);

        // Same-cycle write and read of $ra on both ports.
        drive(1'b1, 5'd31, 32'h00400010, 5'd31, 5'd31);
        #1;
        chk("byp_a_pre", bus_byp.rd_data_a, 32'h00400010);
        chk("byp_b_pre", bus_byp.rd_data_b, 32'h00400010);
        chk("nob_a_pre", bus_nob.rd_data_a, 32'd0);
        chk("nob_b_pre", bus_nob.rd_data_b, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
        #1 chk("nob_a_post", bus_nob.rd_data_a, 32'h00400010);
        tick();

        // Reset asserted on the same edge as a write to $sp.
        drive(1'b1, 5'd29, 32'd5, 5'd29, 5'd29);
        @(posedge clk);
        reset_n = 1'b0;
        model_reset();
        #2 drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd29);
        #5 reset_n = 1'b1;
        tick();
        chk("rvw_byp_29", bus_byp.rd_data_a, 32'd227);
        chk("rvw_nob_29", bus_nob.rd_data_b, 32'd227);
        chk("rvw_ack",    {31'd0, bus_nob.wr_ack}, 32'd0);

        // Back-to-back writes: ack high on three consecutive cycles.
        drive(1'b1, 5'd2, 32'd1, 5'd2, 5'd3);
        tick();
        chk("b2b_ack1", {31'd0, bus_byp.wr_ack}, 32'd1);
        drive(1'b1, 5'd3, 32'd2, 5'd2, 5'd3);
        tick();
        chk("b2b_ack2", {31'd0, bus_byp.wr_ack}, 32'd1);
        drive(1'b1, 5'd2, 32'd9, 5'd2, 5'd3);
        tick();
        chk("b2b_ack3", {31'd0, bus_nob.wr_ack}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd3);
        #1;
        chk("b2b_r2", bus_nob.rd_data_a, 32'd9);
        chk("b2b_r3", bus_nob.rd_data_b, 32'd2);
        tick();
        chk("b2b_ack_drop", {31'd0, bus_byp.wr_ack}, 32'd0);

        // Mixed pattern, often reading the register being written.
        for (int i = 0; i < 40; i++) begin
            drive((i % 4) != 3, 5'((i * 7) % 32), 32'hA5A50000 ^ (32'(i) * 32'h01010101),
                  5'((i * 3) % 32), 5'((i * 7) % 32));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
